// File: rtl/romix_pkg.sv
// Shared sizing constants for the ROMix block loader, datapath and controller.
package romix_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned WORDS  = 32;
    localparam int unsigned BLK_W  = WORD_W * WORDS;
    localparam int unsigned IDX_W  = $clog2(WORDS);

endpackage

// File: rtl/romix_block_loader_if.sv
// Word-stream input and packed-block output bundle of the ROMix block loader.
interface romix_block_loader_if;
    import romix_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [BLK_W-1:0]  m_data;
    logic              err;
    logic [1:0]        fill_level;

    // Environment side: produces words, consumes blocks.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, err, fill_level
    );

    // Loader side.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, err, fill_level
    );

endinterface

// File: rtl/romix_blk_slot.sv
// One ping-pong slot: block register with per-word write enables and a full flag.
module romix_blk_slot #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned WORDS  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [WORDS-1:0]         word_we,
    input  logic [WORD_W-1:0]        wdata,
    input  logic                     set_full,
    input  logic                     clr_full,
    output logic [WORD_W*WORDS-1:0]  data,
    output logic                     full
);

    logic [WORDS-1:0][WORD_W-1:0] data_q;
    logic                         full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (clear) begin
            data_q <= '0;
        end else begin
            for (int k = 0; k < int'(WORDS); k++) begin
                if (word_we[k]) data_q[k] <= wdata;
            end
        end
    end

    // Set and clear never coincide: a slot is filled only while empty, read only while full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
        end else if (clear) begin
            full_q <= 1'b0;
        end else if (set_full) begin
            full_q <= 1'b1;
        end else if (clr_full) begin
            full_q <= 1'b0;
        end
    end

    assign data = data_q;
    assign full = full_q;

endmodule

// File: rtl/romix_block_loader.sv
// Packs a 32-bit word stream into 1024-bit blocks through a two-slot ping-pong buffer.
module romix_block_loader import romix_pkg::*; #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned WORDS     = 32,
    parameter int unsigned BYTE_SWAP = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    romix_block_loader_if.slave  bus
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORDS - 1);

    function automatic logic [WORD_W-1:0] swap_bytes(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int b = 0; b < int'(WORD_W / 8); b++) begin
            r[8*b +: 8] = w[int'(WORD_W) - 8 - 8*b +: 8];
        end
        return r;
    endfunction

    logic                     wr_sel_q, wr_sel_d;
    logic                     rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     err_q, err_d;
    logic [1:0]               full;
    logic [WORD_W*WORDS-1:0]  slot_data [2];
    logic                     s_ready;
    logic                     accept, read, is_last, complete;
    logic [WORDS-1:0]         word_onehot;
    logic [WORD_W-1:0]        wdata;

    assign s_ready     = !full[wr_sel_q];
    assign accept      = bus.s_valid && s_ready;
    assign read        = full[rd_sel_q] && bus.m_ready;
    assign is_last     = idx_q == LastIdx;
    assign complete    = accept && is_last;
    assign word_onehot = WORDS'(1) << idx_q;
    assign wdata       = (BYTE_SWAP != 0) ? swap_bytes(bus.s_data) : bus.s_data;

    for (genvar i = 0; i < 2; i++) begin : g_slot
        logic sel_wr, sel_rd;
        assign sel_wr = wr_sel_q == 1'(i);
        assign sel_rd = rd_sel_q == 1'(i);

        romix_blk_slot #(
            .WORD_W (WORD_W),
            .WORDS  (WORDS)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .clear    (flush),
            .word_we  ((accept && sel_wr) ? word_onehot : '0),
            .wdata    (wdata),
            .set_full (complete && sel_wr),
            .clr_full (read && sel_rd),
            .data     (slot_data[i]),
            .full     (full[i])
        );
    end

    // An early s_last drops the partial block; a missing one still completes it.
    always_comb begin
        idx_d    = idx_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        err_d    = 1'b0;
        if (flush) begin
            idx_d    = '0;
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
        end else begin
            if (accept) begin
                err_d = bus.s_last != is_last;
                if (is_last) begin
                    idx_d    = '0;
                    wr_sel_d = !wr_sel_q;
                end else if (bus.s_last) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            if (read) rd_sel_d = !rd_sel_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            err_q    <= err_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.m_valid    = full[rd_sel_q];
    assign bus.m_data     = rd_sel_q ? slot_data[1] : slot_data[0];
    assign bus.err        = err_q;
    assign bus.fill_level = {1'b0, full[0]} + {1'b0, full[1]};

endmodule

// File: tb/tb_romix_block_loader.sv
// Randomized bench for romix_block_loader against a queue-of-blocks reference model.
module tb_romix_block_loader;
    import romix_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    romix_block_loader_if bus();
    romix_block_loader_if bus_sw();

    assign bus_sw.s_valid = bus.s_valid;
    assign bus_sw.s_data  = bus.s_data;
    assign bus_sw.s_last  = bus.s_last;
    assign bus_sw.m_ready = bus.m_ready;

    romix_block_loader #(.WORD_W(32), .WORDS(32), .BYTE_SWAP(0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );
    romix_block_loader #(.WORD_W(32), .WORDS(32), .BYTE_SWAP(1)) dut_sw (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_sw)
    );

    // Reference model: completed blocks waiting for the consumer, plus the block being built.
    logic [1023:0] q[$];
    logic [1023:0] qs[$];
    logic [31:0]   part[32];
    int            pidx;
    bit            err_exp;
    int            checks = 0;
    int            fails = 0;

    function automatic logic [31:0] rev(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
        return r;
    endfunction

    function automatic logic [4:0] exp_flags();
        return {q.size() < 2, q.size() > 0, 2'(q.size()), err_exp};
    endfunction

    function automatic logic [4:0] obs_flags();
        return {bus.s_ready, bus.m_valid, bus.fill_level, bus.err};
    endfunction

    function automatic void model_clear();
        q.delete();
        qs.delete();
        pidx    = 0;
        err_exp = 1'b0;
    endfunction

    // Drive one cycle from a falling edge; returns at the next falling edge with the model updated.
    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit mr, input bit fl,
                        output bit acc);
        logic [1023:0] b, bs;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.m_ready = mr;
        flush       = fl;
        acc = v && !fl && (q.size() < 2);
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (mr && q.size() > 0) begin
                q.delete(0);
                qs.delete(0);
            end
            err_exp = 1'b0;
            if (acc) begin
                part[pidx] = d;
                err_exp = (l != (pidx == 31));
                if (pidx == 31) begin
                    for (int k = 0; k < 32; k++) begin
                        b[32*k +: 32]  = part[k];
                        bs[32*k +: 32] = rev(part[k]);
                    end
                    q.push_back(b);
                    qs.push_back(bs);
                    pidx = 0;
                end else if (l) begin
                    pidx = 0;
                end else begin
                    pidx++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
        checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.m_data !== '0) begin fails++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
        checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
        checks++; if (bus.fill_level !== 2'd0) begin fails++; $display("FAIL reset_fill: got %0d want 0", bus.fill_level); end
    endtask

    task automatic test_single_block();
        bit acc;
        int errs = 0;
        for (int w = 0; w < 32; w++) begin
            step(1'b1, 32'(w), w == 31, 1'b1, 1'b0, acc);
            if (bus.err === 1'b1) errs++;
            checks++;
            if (obs_flags() !== exp_flags()) begin
                fails++; $display("FAIL single_flags: got %b want %b", obs_flags(), exp_flags());
            end
        end
        checks++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", bus.m_valid); end
        checks++; if (bus.m_data[31:0] !== 32'h0) begin fails++; $display("FAIL single_lsw: got %h want 0", bus.m_data[31:0]); end
        checks++; if (bus.m_data[1023:992] !== 32'h1f) begin fails++; $display("FAIL single_msw: got %h want 1f", bus.m_data[1023:992]); end
        checks++; if (bus.m_data !== q[0]) begin fails++; $display("FAIL single_data: got %h want %h", bus.m_data, q[0]); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        if (bus.err === 1'b1) errs++;
        checks++; if (errs != 0) begin fails++; $display("FAIL single_err: got %0d pulses want 0", errs); end
        checks++; if (obs_flags() !== exp_flags()) begin fails++; $display("FAIL single_drain: got %b want %b", obs_flags(), exp_flags()); end
    endtask

    task automatic test_back_pressure();
        bit acc;
        int n = 0;
        int cyc = 0;
        logic [31:0] cur = $urandom;
        while (n < 64 && cyc < 200) begin
            step(1'b1, cur, (n % 32) == 31, 1'b0, 1'b0, acc);
            cyc++;
            if (acc) begin n++; cur = $urandom; end
            checks++;
            if (obs_flags() !== exp_flags()) begin fails++; $display("FAIL bp_fill_flags: got %b want %b", obs_flags(), exp_flags()); end
        end
        checks++; if (n != 64) begin fails++; $display("FAIL bp_fill_timeout: got %0d accepts want 64", n); end
        checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL bp_s_ready: got %b want 0", bus.s_ready); end
        checks++; if (bus.fill_level !== 2'd2) begin fails++; $display("FAIL bp_fill: got %0d want 2", bus.fill_level); end
        repeat (3) begin
            step(1'b1, cur, (n % 32) == 31, 1'b0, 1'b0, acc);
            checks++;
            if (acc || obs_flags() !== exp_flags()) begin fails++; $display("FAIL bp_stall: got %b want %b", obs_flags(), exp_flags()); end
        end
        checks++; if (bus.m_data !== q[0]) begin fails++; $display("FAIL bp_block0: got %h want %h", bus.m_data, q[0]); end
        step(1'b1, cur, (n % 32) == 31, 1'b1, 1'b0, acc);
        checks++; if (bus.m_data !== q[0]) begin fails++; $display("FAIL bp_block1: got %h want %h", bus.m_data, q[0]); end
        checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back: got %b want 1", bus.s_ready); end
        while (n < 96 && cyc < 400) begin
            step(1'b1, cur, (n % 32) == 31, 1'b0, 1'b0, acc);
            cyc++;
            if (acc) begin n++; cur = $urandom; end
            checks++;
            if (obs_flags() !== exp_flags()) begin fails++; $display("FAIL bp_load2_flags: got %b want %b", obs_flags(), exp_flags()); end
        end
        checks++; if (n != 96) begin fails++; $display("FAIL bp_load2_timeout: got %0d accepts want 96", n); end
        while (q.size() > 0 && cyc < 500) begin
            checks++;
            if (bus.m_data !== q[0]) begin fails++; $display("FAIL bp_drain_data: got %h want %h", bus.m_data, q[0]); end
            step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
            cyc++;
        end
        checks++; if (obs_flags() !== exp_flags()) begin fails++; $display("FAIL bp_drain_flags: got %b want %b", obs_flags(), exp_flags()); end
    endtask

    task automatic test_early_last();
        bit acc;
        int errs = 0;
        int valids = 0;
        for (int w = 0; w < 11; w++) begin
            step(1'b1, $urandom, w == 10, 1'b1, 1'b0, acc);
            if (bus.err === 1'b1) errs++;
            if (bus.m_valid === 1'b1) valids++;
        end
        checks++; if (bus.err !== 1'b1) begin fails++; $display("FAIL early_err_now: got %b want 1", bus.err); end
        repeat (3) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
            if (bus.err === 1'b1) errs++;
            if (bus.m_valid === 1'b1) valids++;
        end
        checks++; if (errs != 1) begin fails++; $display("FAIL early_err_count: got %0d want 1", errs); end
        checks++; if (valids != 0) begin fails++; $display("FAIL early_no_valid: got %0d cycles want 0", valids); end
        for (int w = 0; w < 32; w++) begin
            step(1'b1, $urandom, w == 31, 1'b0, 1'b0, acc);
            checks++;
            if (obs_flags() !== exp_flags()) begin fails++; $display("FAIL early_reload_flags: got %b want %b", obs_flags(), exp_flags()); end
        end
        checks++; if (q.size() != 1 || bus.m_data !== q[0]) begin fails++; $display("FAIL early_block: got %h", bus.m_data); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_missing_last();
        bit acc;
        for (int w = 0; w < 32; w++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, acc);
        checks++; if (bus.err !== 1'b1) begin fails++; $display("FAIL missing_err: got %b want 1", bus.err); end
        checks++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL missing_valid: got %b want 1", bus.m_valid); end
        checks++; if (q.size() != 1 || bus.m_data !== q[0]) begin fails++; $display("FAIL missing_data: got %h", bus.m_data); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        checks++; if (obs_flags() !== exp_flags()) begin fails++; $display("FAIL missing_after: got %b want %b", obs_flags(), exp_flags()); end
    endtask

    task automatic test_byte_swap();
        bit acc;
        step(1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0, acc);
        for (int w = 1; w < 32; w++) step(1'b1, $urandom, w == 31, 1'b0, 1'b0, acc);
        checks++; if (bus_sw.m_data[31:0] !== 32'h44332211) begin fails++; $display("FAIL swap_word0: got %h want 44332211", bus_sw.m_data[31:0]); end
        checks++; if (bus.m_data[31:0] !== 32'h11223344) begin fails++; $display("FAIL noswap_word0: got %h want 11223344", bus.m_data[31:0]); end
        checks++; if (qs.size() != 1 || bus_sw.m_data !== qs[0]) begin fails++; $display("FAIL swap_block: got %h", bus_sw.m_data); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_flush();
        bit acc;
        logic [31:0] w0;
        for (int w = 0; w < 49; w++) step(1'b1, $urandom, w == 31, 1'b0, 1'b0, acc);
        checks++; if (bus.fill_level !== 2'd1) begin fails++; $display("FAIL flush_pre_fill: got %0d want 1", bus.fill_level); end
        step(1'b1, $urandom, 1'b1, 1'b1, 1'b1, acc);
        checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.fill_level !== 2'd0) begin fails++; $display("FAIL flush_fill: got %0d want 0", bus.fill_level); end
        checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b want 1", bus.s_ready); end
        checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL flush_err: got %b want 0", bus.err); end
        checks++; if (bus.m_data !== '0) begin fails++; $display("FAIL flush_data: got %h want 0", bus.m_data); end
        w0 = $urandom;
        step(1'b1, w0, 1'b0, 1'b0, 1'b0, acc);
        for (int w = 1; w < 32; w++) step(1'b1, $urandom, w == 31, 1'b0, 1'b0, acc);
        checks++; if (bus.m_data[31:0] !== w0) begin fails++; $display("FAIL flush_reload_w0: got %h want %h", bus.m_data[31:0], w0); end
        checks++; if (q.size() != 1 || bus.m_data !== q[0]) begin fails++; $display("FAIL flush_reload: got %h", bus.m_data); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_reset_mid();
        bit acc;
        for (int w = 0; w < 49; w++) step(1'b1, $urandom, w == 31, 1'b0, 1'b0, acc);
        bus.s_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_clear();
        checks++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.fill_level !== 2'd0) begin fails++; $display("FAIL rst_mid_fill: got %0d want 0", bus.fill_level); end
        checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b want 1", bus.s_ready); end
        checks++; if (bus.m_data !== '0) begin fails++; $display("FAIL rst_mid_data: got %h want 0", bus.m_data); end
        @(negedge clk);
        reset = 1'b0;
        for (int w = 0; w < 32; w++) step(1'b1, $urandom, w == 31, 1'b0, 1'b0, acc);
        checks++; if (q.size() != 1 || bus.m_data !== q[0] || bus.err !== 1'b0) begin fails++; $display("FAIL rst_mid_reload: got %h", bus.m_data); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_random();
        bit acc;
        bit v, l, mr;
        for (int c = 0; c < 500; c++) begin
            v  = $urandom_range(9) < 8;
            mr = $urandom_range(1) == 1;
            l  = (pidx == 31) ? ($urandom_range(9) != 0) : ($urandom_range(30) == 0);
            step(v, $urandom, l, mr, 1'b0, acc);
            checks++;
            if (obs_flags() !== exp_flags()) begin fails++; $display("FAIL rand_flags: cycle %0d got %b want %b", c, obs_flags(), exp_flags()); end
            if (q.size() > 0) begin
                checks++;
                if (bus.m_data !== q[0] || bus_sw.m_data !== qs[0]) begin
                    fails++; $display("FAIL rand_data: cycle %0d got %h want %h", c, bus.m_data, q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_pressure();
        test_early_last();
        test_missing_last();
        test_byte_swap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
